// File: rtl/mult_seq_nbyn_if.sv
// Operand/product handshake bundle for mult_seq_nbyn.
interface mult_seq_nbyn_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mult_seq_nbyn.sv
// Sequential WIDTH x WIDTH unsigned shift-add multiplier, one partial-product row per clock.
// Optional MULT_SEQ_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | accumulating one partial-product row per clock, busy high
// DONE  | out_valid high, p holds product until out_ready
module mult_seq_nbyn #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    mult_seq_nbyn_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] xr, yr;
    logic [PW-1:0]   acc, p_r, row, sum;
    logic [CW-1:0]   cnt;
    logic            last_row;
    logic            in_ready, out_valid, busy;

    assign row = yr[0] ? ({{WIDTH{1'b0}}, xr} << cnt) : '0;
    assign sum = acc + row;

`ifdef MULT_SEQ_EARLY_TERM_EN
    // Post-shift multiplier empty means every remaining row would add zero.
    assign last_row = (cnt == LAST_ROW) || (yr[WIDTH-1:1] == '0);
`else
    assign last_row = (cnt == LAST_ROW);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_row) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p is a separate register so it survives the acc clear on the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr  <= '0;
            yr  <= '0;
            acc <= '0;
            cnt <= '0;
            p_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xr  <= bus.x;
                        yr  <= bus.y;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    yr  <= yr >> 1;
                    cnt <= cnt + 1'b1;
                    if (last_row) p_r <= sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.p         = p_r;
endmodule

// File: tb/tb_mult_seq_nbyn.sv
// Scoreboard bench for mult_seq_nbyn: a WIDTH=4 instance driven through a queue-based monitor,
// plus a WIDTH=8 instance for directed wide-operand and latency cases.
module tb_mult_seq_nbyn;
    localparam int W  = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_seq_nbyn_if #(.WIDTH(W))  b4 ();
    mult_seq_nbyn_if #(.WIDTH(W8)) b8 ();

    mult_seq_nbyn #(.WIDTH(W))  dut4 (.clk(clk), .reset(reset), .bus(b4));
    mult_seq_nbyn #(.WIDTH(W8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int p;
        int lat;
        int acc;
    } txn_t;

    txn_t sbq[$];
    int   last_p = 0;
    bit   seen = 1'b0;
    int   busy_run = 0;
    bit   gap_en = 1'b0;
    int   prev_acc = -1;
    int   prev_lat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rows processed: all WIDTH rows, or up to the highest set multiplier bit with early exit.
    function automatic int model_lat(input int width, input int y);
`ifdef MULT_SEQ_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < width; i++) if (y[i]) h = i + 1;
        return (h == 0) ? 1 : h;
`else
        if (y < 0) return 0;
        return width;
`endif
    endfunction

    // Monitor: compares every presented product against the head of the scoreboard.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (b4.busy) busy_run++;
            chk("ready_exclusive", {63'd0, b4.in_ready & (b4.busy | b4.out_valid)}, 64'd0);
            if (b4.out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
                        chk("busy_cycles", 64'(busy_run), 64'(sbq[0].lat));
                        busy_run = 0;
                        seen = 1'b1;
                    end
                    chk("product", 64'(b4.p), 64'(sbq[0].p));
                    if (b4.out_ready) begin
                        last_p = sbq[0].p;
                        void'(sbq.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                chk("p_hold", 64'(b4.p), 64'(last_p));
            end
        end
    end

    // Offers x/y until accepted; junk operands before and after the accept edge.
    task automatic issue(input int x, input int y);
        int  n = 0;
        bit  done = 1'b0;
        txn_t t;
        @(negedge clk);
        b4.in_valid = 1'b1;
        while (!done) begin
            if (b4.in_ready) begin
                b4.x = W'(x);
                b4.y = W'(y);
                t.x = x; t.y = y; t.p = x * y;
                t.lat = model_lat(W, y);
                t.acc = cyc + 1;
                sbq.push_back(t);
                if (gap_en && prev_acc >= 0)
                    chk("issue_gap", 64'(t.acc - prev_acc), 64'(prev_lat + 2));
                prev_acc = t.acc;
                prev_lat = t.lat;
                done = 1'b1;
                @(posedge clk);
                #1;
                b4.x = W'($urandom_range(0, 15));
                b4.y = W'($urandom_range(0, 15));
            end else begin
                b4.x = W'($urandom_range(0, 15));
                b4.y = W'($urandom_range(0, 15));
                n++;
                if (n > 50) begin
                    chk("accept_timeout", 64'd0, 64'd1);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    task automatic run8(input int x, input int y);
        int lat = 0;
        int bc = 0;
        @(negedge clk);
        b8.x = W8'(x);
        b8.y = W8'(y);
        b8.in_valid = 1'b1;
        b8.out_ready = 1'b1;
        chk("w8_in_ready", {63'd0, b8.in_ready}, 64'd1);
        @(negedge clk);
        b8.in_valid = 1'b0;
        b8.x = W8'($urandom_range(0, 255));
        b8.y = W8'($urandom_range(0, 255));
        while (!b8.out_valid && lat < 40) begin
            if (b8.busy) bc++;
            lat++;
            @(negedge clk);
        end
        chk("w8_latency", 64'(lat), 64'(model_lat(W8, y)));
        chk("w8_busy_cycles", 64'(bc), 64'(model_lat(W8, y)));
        chk("w8_product", 64'(b8.p), 64'(x * y));
    endtask

    initial begin
        int n;
        b4.in_valid = 1'b0; b4.x = '0; b4.y = '0; b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.out_ready = 1'b1;
        #2;
        chk("rst_in_ready", {63'd0, b4.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, b4.busy}, 64'd0);
        chk("rst_p", 64'(b4.p), 64'd0);
        chk("rst_w8_in_ready", {63'd0, b8.in_ready}, 64'd1);
        chk("rst_w8_p", 64'(b8.p), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Exhaustive WIDTH=4 stream with out_ready and in_valid held high.
        gap_en = 1'b1;
        prev_acc = -1;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                issue(x, y);
        @(negedge clk);
        b4.in_valid = 1'b0;
        drain();

        prev_acc = -1;
        for (int i = 0; i < 30; i++)
            issue($urandom_range(0, 15), $urandom_range(0, 15));
        @(negedge clk);
        b4.in_valid = 1'b0;
        drain();
        gap_en = 1'b0;

        // Backpressure in DONE with a competing operand offer.
        b4.out_ready = 1'b0;
        issue(13, 11);
        b4.x = W'(1);
        b4.y = W'(1);
        n = 0;
        while (!b4.out_valid && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("bp_reached_done", {63'd0, b4.out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk("bp_in_ready", {63'd0, b4.in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, b4.out_valid}, 64'd1);
            chk("bp_p", 64'(b4.p), 64'd143);
        end
        @(negedge clk);
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {62'd0, b4.in_ready, b4.out_valid}, 64'd2);
        drain();

        // Asynchronous reset two rows into RUN discards the in-flight product.
        issue(7, 9);
        b4.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", {63'd0, b4.in_ready}, 64'd1);
        chk("mid_rst_out_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, b4.busy}, 64'd0);
        chk("mid_rst_p", 64'(b4.p), 64'd0);
        sbq.delete();
        last_p = 0;
        seen = 1'b0;
        busy_run = 0;
        @(negedge clk);
        reset = 1'b0;
        issue(3, 5);
        b4.in_valid = 1'b0;
        drain();
        chk("post_rst_product", 64'(last_p), 64'd15);

        // Wide-operand and early-termination cases on the WIDTH=8 instance.
        run8(255, 255);
        run8(200, 1);
        run8(77, 128);
        run8(123, 0);
        for (int i = 0; i < 6; i++)
            run8($urandom_range(0, 255), $urandom_range(0, 255));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mult_seq_nbyn.md
# mult_seq_nbyn

Parametrised sequential unsigned multiplier. It computes `WIDTH x WIDTH -> 2*WIDTH` products one partial-product row per clock, reusing a single row of mux/adder cells instead of a full combinational array. It uses valid/ready handshakes on both sides. It is the area-optimised, pipelinable successor to the fixed 2x2 combinational array multiplier, and sits between operand producers and result consumers in the datapath.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits; legal values ≥ 2.

Ports (name, direction, width, meaning):
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `in_valid`, in, 1: operands `x`/`y` are presented.
- `in_ready`, out, 1: block can accept operands.
- `x`, in, `WIDTH`: multiplicand (unsigned).
- `y`, in, `WIDTH`: multiplier (unsigned).
- `out_valid`, out, 1: `p` holds a completed product.
- `out_ready`, in, 1: consumer takes the product.
- `p`, out, `2*WIDTH`: product `x*y`.
- `busy`, out, 1: high in RUN state.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Registers:
  - `xr` (`WIDTH`): latched multiplicand.
  - `yr` (`WIDTH`): latched multiplier.
  - `acc` (`2*WIDTH`): running sum.
  - `cnt` (`clog2(WIDTH)+1`): row counter.
- IDLE:
  - `in_ready=1`.
  - On an edge with `in_valid=1`: latch `xr=x`, `yr=y`; clear `acc=0`, `cnt=0`; go to RUN.
- RUN, one row per edge:
  - `acc <= acc + (yr[0] ? xr << cnt : 0)`.
  - `yr <= yr >> 1`.
  - `cnt <= cnt + 1`.
  - After the row with `cnt == WIDTH-1`, go to DONE.
- DONE:
  - `out_valid=1`; `p` equals `acc`, the full product.
  - On an edge with `out_ready=1`, go to IDLE.
- Arithmetic rules:
  - Exact unsigned result with no overflow; the sum never exceeds `2*WIDTH` bits.
  - Internal adder width is `2*WIDTH`.
- `p` holds the last completed product until the next completion. It does not change in IDLE or RUN.
- `x`/`y` are sampled only on the accept edge. Later changes have no effect.
- `in_valid` outside IDLE is ignored (`in_ready=0`). No queuing.
- `out_ready` outside DONE is ignored.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `busy=0`, `p=0`; internal `acc`, `xr`, `yr`, `cnt` = 0.
- `in_ready`, `out_valid` and `busy` are Moore outputs, decoded from state only.
- Latency, accept edge at cycle k:
  - `out_valid` rises after edge k+`WIDTH`.
  - So RUN lasts exactly `WIDTH` cycles.
- `out_ready` held high in DONE: one DONE cycle, IDLE on the next edge.
- Minimum issue period is `WIDTH+2` cycles: accept, `WIDTH` rows, DONE handshake.
- Backpressure: while `out_ready=0`, the block stays in DONE with `p` and `out_valid` stable, and `in_ready` stays 0.
- Reset asserted mid-RUN or in DONE:
  - Outputs go to reset values asynchronously.
  - The in-flight product is discarded.
  - The first accept after deassertion behaves as from power-up.
- `WIDTH=2` is legal: 2 RUN cycles.

## Configuration
- Macro: `MULT_SEQ_EARLY_TERM_EN`.
- Defined:
  - RUN also exits to DONE after any row where the post-shift `yr == 0`.
  - Rows processed = max(1, index of highest set bit of `y` + 1).
  - Latency is therefore 1..`WIDTH` cycles; `y=0` gives 1 RUN cycle with `p=0`.
  - The product value is identical to the undefined case.
- Undefined: fixed latency of `WIDTH` cycles, as specified above. No early-exit logic is synthesised.

## Test plan
- **Exhaustive, `WIDTH=4`, macro off:** all 256 `{x,y}` pairs, `out_ready=1`.
  - `p == x*y` every time.
  - `out_valid` exactly 4 cycles after accept.
- **Max operands, `WIDTH=8`:** `x=255`, `y=255`.
  - `p=65025` (0xFE01) after 8 RUN cycles.
  - `busy` high for exactly those 8 cycles.
- **Backpressure, `WIDTH=4`:** `x=13`, `y=11`, hold `out_ready=0` for 5 cycles in DONE.
  - `p=143` stays stable, `out_valid=1`, `in_ready=0`.
  - A new `in_valid` during that window is not accepted.
  - Raise `out_ready`: IDLE on the next cycle.
- **Reset mid-operation:** assert `reset` 2 cycles into RUN.
  - All outputs go to reset values without waiting for a clock edge.
  - Next op `x=3`, `y=5` yields `p=15`.
- **Early termination, `WIDTH=8`, macro on:**
  - `y=1`, `x=200`: `p=200` after 1 RUN cycle.
  - `y=0x80`: 8 cycles.
  - `y=0`: `p=0` after 1 cycle.
  - Rebuild with the macro off: all three take 8 cycles with the same products.
- **Back-to-back, `WIDTH=4`:** `in_valid` and `out_ready` held high with streaming random operands.
  - One accept every 6 cycles.
  - Every product correct; no operand dropped or duplicated.
